div_stall_unit: RTL and testbench

//  Multi-cycle 32-bit MIPS DIV/DIVU engine in the EX stage; the stall *requester* feeding the hazard unit.

---
 rtl/div_stall_unit.sv | 145 ++++++++++++++
 tb/tb_div_stall_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_stall_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU engine for the EX stage.
// Holds a stall request toward the hazard unit while a divide is pending.
module div_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_req_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic             accept;
  logic             b_zero;
  logic             last_iter;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] r_new, q_new;
  logic [WIDTH-1:0] hi_fin, lo_fin;

  assign accept    = (state_reg == IDLE) && start_i && !annul_i;
  assign b_zero    = (b_i == '0);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Magnitudes only differ from the raw operands for negative signed inputs.
  assign a_abs = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_abs = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // One restoring step: shift {R,Q} left, subtract the divisor if it fits.
  always_comb begin
    r_sh  = {r_reg, q_reg[WIDTH-1]};
    q_sh  = {q_reg[WIDTH-2:0], 1'b0};
    r_new = r_sh[WIDTH-1:0];
    q_new = q_sh;
    if (r_sh >= {1'b0, b_reg}) begin
      r_new = r_sh[WIDTH-1:0] - b_reg;
      q_new = q_sh | WIDTH'(1);
    end
  end

  assign lo_fin = sign_q_reg ? -q_new : q_new;
  assign hi_fin = sign_r_reg ? -r_new : r_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      r_reg      <= '0;
      q_reg      <= '0;
      b_reg      <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg    <= '0;
            r_reg      <= '0;
            q_reg      <= a_abs;
            b_reg      <= b_abs;
            sign_q_reg <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            sign_r_reg <= signed_i && a_i[WIDTH-1];
            // Division by zero returns the dividend as remainder, all-ones quotient.
            if (b_zero) begin
              hi_reg <= a_i;
              lo_reg <= '1;
            end
          end
        end
        BUSY: begin
          if (!annul_i) begin
            r_reg   <= r_new;
            q_reg   <= q_new;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_iter) begin
              hi_reg <= hi_fin;
              lo_reg <= lo_fin;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Low in DONE so the instruction can leave EX while its result is shown.
  assign stall_req_o = accept || (state_reg == BUSY);
  assign busy_o      = (state_reg == BUSY);
  assign ready_o     = (state_reg == DONE);
  assign hi_o        = hi_reg;
  assign lo_o        = lo_reg;

endmodule

// File: tb/tb_div_stall_unit.sv
// Scoreboard bench for div_stall_unit: driver pushes reference results,
// a negedge monitor pops and compares on every ready_o pulse.
module tb_div_stall_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         signed_i;
  logic         annul_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         stall_req_o;
  logic         busy_o;
  logic         ready_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [63:0] last_res;

  div_stall_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .stall_req_o (stall_req_o),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
    end
    return {a % b, a / b};
  endfunction

  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got hi=%h lo=%h expected no result", hi_o, lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        $display("result hi=%h lo=%h (expect hi=%h lo=%h)", hi_o, lo_o, mon_e[63:32], mon_e[31:0]);
        check("hi", hi_o, mon_e[63:32]);
        check("lo", lo_o, mon_e[31:0]);
      end
    end
  end

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int lat;
    int stall_cnt;
    bit got;
    @(posedge clk);
    #1;
    start_i  = 1'b1;
    annul_i  = 1'b0;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    last_res = model(a, b, s);
    exp_q.push_back(last_res);
    #1;
    stall_cnt = stall_req_o ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        got = 1'b1;
        lat = k;
        check("stall_in_done", {31'b0, stall_req_o}, 32'd0);
        start_i = 1'b0;
      end else if (stall_req_o) begin
        stall_cnt++;
      end
    end
    if (!got) begin
      start_i = 1'b0;
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready_o in 40 cycles expected latency %0d", (b == 0) ? 1 : W + 1);
      void'(exp_q.pop_back());
    end else begin
      check("latency", lat, (b == 0) ? 32'd1 : 32'(W + 1));
      check("stall_cycles", stall_cnt, (b == 0) ? 32'd1 : 32'(W + 1));
    end
  endtask

  logic [W-1:0] ra, rb;
  int sel;

  initial begin
    rst      = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    annul_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    last_res = '0;
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_ready", {31'b0, ready_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'h1234, 32'd0, 1'b1);
    do_div(32'd1000, 32'd9, 1'b0);

    // Annul in BUSY cycle 10: no result, registers keep the previous value.
    @(posedge clk);
    #1;
    start_i = 1'b1; a_i = 32'd5000; b_i = 32'd3; signed_i = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("busy_before_annul", {31'b0, busy_o}, 1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul_busy", {31'b0, busy_o}, 0);
    check("annul_stall", {31'b0, stall_req_o}, 0);
    check("annul_ready", {31'b0, ready_o}, 0);
    check("annul_hi_kept", hi_o, last_res[63:32]);
    check("annul_lo_kept", lo_o, last_res[31:0]);
    repeat (40) @(posedge clk);
    do_div(32'd77, 32'd5, 1'b0);

    // start together with annul in IDLE is not accepted.
    @(posedge clk);
    #1;
    start_i = 1'b1; annul_i = 1'b1; a_i = 32'd9; b_i = 32'd2;
    #1;
    check("idle_annul_stall", {31'b0, stall_req_o}, 0);
    @(posedge clk);
    #1;
    check("idle_annul_busy", {31'b0, busy_o}, 0);
    start_i = 1'b0; annul_i = 1'b0;

    // Asynchronous reset mid-BUSY.
    @(posedge clk);
    #1;
    start_i = 1'b1; a_i = 32'd123456; b_i = 32'd789; signed_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    start_i = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_hi", hi_o, 0);
    check("arst_lo", lo_o, 0);
    check("arst_busy", {31'b0, busy_o}, 0);
    check("arst_stall", {31'b0, stall_req_o}, 0);
    check("arst_ready", {31'b0, ready_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd123456, 32'd789, 1'b0);

    // Random back-to-back divides.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      if (sel == 9) ra = 32'h8000_0000;
      case (sel)
        0:       rb = '0;
        1, 2, 3: rb = $urandom_range(1, 15);
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_div(ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
